// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg : shared encodings and payload type for the port arbiter
// Rev 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int MEM_REQ_WD = 71;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Reads never carry byte enables downstream.
    function automatic mem_req_t pack_req(
        input logic        wr,
        input logic [1:0]  size,
        input logic [3:0]  wstrb,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        mem_req_t r;
        r.wr    = wr;
        r.size  = size;
        r.wstrb = wr ? wstrb : 4'b0000;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : sram-like request/response port with master/slave views
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_req_reg.sv
`default_nettype none
// ============================================================================
// mem_req_reg : granted-request payload latch with async clear and load enable
// Rev 1.0
// ============================================================================
module mem_req_reg
    import mem_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic [MEM_REQ_WD-1:0] d_i,
    output logic [MEM_REQ_WD-1:0] q_o
);

    logic [MEM_REQ_WD-1:0] payload_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            payload_q <= '0;
        end else if (load_i) begin
            payload_q <= d_i;
        end
    end

    assign q_o = payload_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between inst fetch and data access
// Rev 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.slave  inst_bus,
    mem_port_arbiter_if.slave  data_bus,
    mem_port_arbiter_if.master mem_bus
);

    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       state_q,  state_d;
    logic             owner_q,  owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic     w_idle;
    logic     w_grant_inst;
    logic     w_grant_data;
    logic     w_load;
    logic     w_resp;
    mem_req_t w_req_sel;
    mem_req_t w_req_lat;

    // Grants are gated by resetn so no addr_ok escapes while reset is held.
    assign w_idle       = (state_q == ST_IDLE) && resetn;
    assign w_grant_inst = w_idle && inst_bus.req &&
                          (!data_bus.req || (starve_q == STARVE_LIM));
    assign w_grant_data = w_idle && data_bus.req && !w_grant_inst;
    assign w_load       = w_grant_inst || w_grant_data;

    always_comb begin
        if (w_grant_data) begin
            w_req_sel = pack_req(data_bus.wr, data_bus.size, data_bus.wstrb,
                                 data_bus.addr, data_bus.wdata);
        end else begin
            w_req_sel = pack_req(inst_bus.wr, inst_bus.size, inst_bus.wstrb,
                                 inst_bus.addr, inst_bus.wdata);
        end
    end

    mem_req_reg u_req_reg (
        .clk    (clk),
        .resetn (resetn),
        .load_i (w_load),
        .d_i    (w_req_sel),
        .q_o    (w_req_lat)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_INST;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                if (w_load) begin
                    state_d = ST_REQ;
                    owner_d = w_grant_data ? OWN_DATA : OWN_INST;
                    // Only data grants that overtake a waiting inst count.
                    if (w_grant_inst) begin
                        starve_d = '0;
                    end else if (inst_bus.req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            ST_REQ: begin
                if (mem_bus.addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_bus.data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_resp           = (state_q == ST_WAIT) && mem_bus.data_ok;
        inst_bus.addr_ok = w_grant_inst;
        data_bus.addr_ok = w_grant_data;
        inst_bus.data_ok = w_resp && (owner_q == OWN_INST);
        data_bus.data_ok = w_resp && (owner_q == OWN_DATA);
        inst_bus.rdata   = mem_bus.rdata;
        data_bus.rdata   = mem_bus.rdata;
        mem_bus.req      = (state_q == ST_REQ);
        mem_bus.wr       = w_req_lat.wr;
        mem_bus.size     = w_req_lat.size;
        mem_bus.wstrb    = w_req_lat.wstrb;
        mem_bus.addr     = w_req_lat.addr;
        mem_bus.wdata    = w_req_lat.wdata;
    end

    a_resp_only_in_wait : assert property (
        @(posedge clk) disable iff (!resetn)
        mem_bus.data_ok |-> (state_q == ST_WAIT)
    );

    a_no_inst_ok_overlap : assert property (
        @(posedge clk) disable iff (!resetn)
        !(inst_bus.addr_ok && inst_bus.data_ok)
    );

    a_no_data_ok_overlap : assert property (
        @(posedge clk) disable iff (!resetn)
        !(data_bus.addr_ok && data_bus.data_ok)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed and random checks against a transaction model
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic clk;
    logic resetn;

    mem_port_arbiter_if inst_if ();
    mem_port_arbiter_if data_if ();
    mem_port_arbiter_if mem_if ();

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .inst_bus (inst_if),
        .data_bus (data_if),
        .mem_bus  (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: phase 0 free, 1 request on the bus, 2 awaiting reply.
    int          ph = 0;
    int          own = 0;
    int          starve = 0;
    int          cyc = 0;
    bit          s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    bit          hold_inst = 0;
    bit          hold_data = 0;
    int          obs_q[$];
    int          obs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit i, input bit d, input int s);
        if (i && d) return (s == STARVE_MAX) ? 0 : 1;
        if (d) return 1;
        if (i) return 0;
        return -1;
    endfunction

    task automatic new_inst(input bit wr);
        inst_if.req   = 1'b1;
        inst_if.wr    = wr;
        inst_if.size  = 2'($urandom_range(0, 2));
        inst_if.wstrb = 4'($urandom);
        inst_if.addr  = $urandom;
        inst_if.wdata = $urandom;
    endtask

    task automatic new_data(input bit wr);
        data_if.req   = 1'b1;
        data_if.wr    = wr;
        data_if.size  = 2'($urandom_range(0, 2));
        data_if.wstrb = 4'($urandom);
        data_if.addr  = $urandom;
        data_if.wdata = $urandom;
    endtask

    task automatic auto_mem();
        mem_if.addr_ok = (ph == 1);
        mem_if.data_ok = (ph == 2);
        mem_if.rdata   = $urandom;
    endtask

    task automatic step();
        int win;
        #1;
        win = (ph == 0) ? pick(inst_if.req, data_if.req, starve) : -1;
        chk("inst_addr_ok", 32'(inst_if.addr_ok), 32'(win == 0));
        chk("data_addr_ok", 32'(data_if.addr_ok), 32'(win == 1));
        chk("m_req", 32'(mem_if.req), 32'(ph == 1));
        chk("inst_data_ok", 32'(inst_if.data_ok), 32'(ph == 2 && mem_if.data_ok && own == 0));
        chk("data_data_ok", 32'(data_if.data_ok), 32'(ph == 2 && mem_if.data_ok && own == 1));
        if (ph == 2) begin
            chk("inst_rdata", inst_if.rdata, mem_if.rdata);
            chk("data_rdata", data_if.rdata, mem_if.rdata);
        end
        if (ph == 1) begin
            chk("m_addr", mem_if.addr, s_addr);
            chk("m_wdata", mem_if.wdata, s_wdata);
            chk("m_wr", 32'(mem_if.wr), 32'(s_wr));
            chk("m_size", 32'(mem_if.size), 32'(s_size));
            chk("m_wstrb", 32'(mem_if.wstrb), 32'(s_wstrb));
        end
        if (inst_if.addr_ok) begin obs_q.push_back(0); obs_cyc.push_back(cyc); end
        if (data_if.addr_ok) begin obs_q.push_back(1); obs_cyc.push_back(cyc); end
        if (win >= 0) begin
            if (win == 0) begin
                s_wr = inst_if.wr; s_size = inst_if.size; s_wstrb = inst_if.wstrb;
                s_addr = inst_if.addr; s_wdata = inst_if.wdata;
                starve = 0;
            end else begin
                s_wr = data_if.wr; s_size = data_if.size; s_wstrb = data_if.wstrb;
                s_addr = data_if.addr; s_wdata = data_if.wdata;
                if (inst_if.req && starve < STARVE_MAX) starve++;
            end
            if (!s_wr) s_wstrb = 4'b0000;
            own = win;
            ph  = 1;
        end else if (ph == 1 && mem_if.addr_ok) begin
            ph = 2;
        end else if (ph == 2 && mem_if.data_ok) begin
            ph = 0;
        end
        cyc++;
        @(negedge clk);
        if (win == 0 && !hold_inst) inst_if.req = 1'b0;
        if (win == 1 && !hold_data) data_if.req = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((ph != 0 || inst_if.req || data_if.req) && n < 40) begin
            auto_mem();
            step();
            n++;
        end
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b0;
        chk(tag, 32'(n < 40), 32'd1);
    endtask

    initial begin
        int n;
        int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        logic [31:0] stall_addr;

        resetn = 1'b0;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.wstrb = 0;
        inst_if.addr = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.wstrb = 0;
        data_if.addr = 0; data_if.wdata = 0;
        mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_req", 32'(mem_if.req), 32'd0);
        chk("rst_m_addr", mem_if.addr, 32'd0);
        chk("rst_m_wdata", mem_if.wdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single data write with one cycle of downstream response delay.
        data_if.req = 1; data_if.wr = 1; data_if.size = 2'b10; data_if.wstrb = 4'hF;
        data_if.addr = 32'h1C000100; data_if.wdata = 32'hDEADBEEF;
        step();
        mem_if.addr_ok = 1;
        #1 chk("t1_m_addr", mem_if.addr, 32'h1C000100);
        step();
        mem_if.addr_ok = 0;
        step();
        mem_if.data_ok = 1; mem_if.rdata = $urandom;
        step();
        mem_if.data_ok = 0;
        step();

        // Both requesting: data first, inst right after data's response.
        obs_q.delete(); obs_cyc.delete();
        new_inst(0); inst_if.addr = 32'h1C000000;
        new_data(1); data_if.addr = 32'h00000010;
        n = 0;
        while (obs_q.size() < 2 && n < 20) begin auto_mem(); step(); n++; end
        chk("t2_grants", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            chk("t2_first", 32'(obs_q[0]), 32'd1);
            chk("t2_second", 32'(obs_q[1]), 32'd0);
            chk("t2_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd3);
        end
        auto_mem();
        #1 chk("t2_m_addr", mem_if.addr, 32'h1C000000);
        step();
        drain("t2_drain");

        // Starvation guard with both requests held continuously.
        obs_q.delete(); obs_cyc.delete();
        hold_inst = 1; hold_data = 1;
        new_inst(0); new_data(1);
        n = 0;
        while (obs_q.size() < 10 && n < 60) begin auto_mem(); step(); n++; end
        hold_inst = 0; hold_data = 0;
        chk("t3_grants", 32'(obs_q.size() >= 10), 32'd1);
        if (obs_q.size() >= 10)
            for (int i = 0; i < 10; i++) chk($sformatf("t3_seq%0d", i), 32'(obs_q[i]), 32'(exp_seq[i]));
        drain("t3_drain");

        // Read: wstrb suppressed, response routed to data only.
        data_if.req = 1; data_if.wr = 0; data_if.size = 2'b10; data_if.wstrb = 4'hF;
        data_if.addr = $urandom; data_if.wdata = $urandom;
        step();
        mem_if.addr_ok = 1;
        #1 chk("t4_m_wstrb", 32'(mem_if.wstrb), 32'd0);
        step();
        mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h12345678;
        #1;
        chk("t4_data_rdata", data_if.rdata, 32'h12345678);
        chk("t4_data_data_ok", 32'(data_if.data_ok), 32'd1);
        chk("t4_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
        step();
        mem_if.data_ok = 0;

        // Downstream stall of five cycles with a late inst request.
        new_data(1);
        stall_addr = data_if.addr;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) new_inst(1);
            #1 chk("t5_m_addr", mem_if.addr, stall_addr);
            step();
        end
        drain("t5_drain");

        // Asynchronous reset while awaiting the response.
        new_data(1);
        step();
        mem_if.addr_ok = 1;
        step();
        mem_if.addr_ok = 0;
        new_inst(0);
        #1 resetn = 1'b0;
        #1;
        chk("t6_m_req", 32'(mem_if.req), 32'd0);
        chk("t6_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
        chk("t6_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
        chk("t6_m_addr", mem_if.addr, 32'd0);
        chk("t6_m_wdata", mem_if.wdata, 32'd0);
        @(negedge clk);
        mem_if.data_ok = 1;
        #1;
        chk("t6_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
        chk("t6_data_data_ok", 32'(data_if.data_ok), 32'd0);
        @(negedge clk);
        mem_if.data_ok = 0;
        ph = 0; own = 0; starve = 0;
        #1 resetn = 1'b1;
        step();
        drain("t6_drain");

        // Randomized traffic with random downstream latency.
        for (int i = 0; i < 400; i++) begin
            if (!inst_if.req && $urandom_range(0, 2) == 0) new_inst(1'($urandom));
            if (!data_if.req && $urandom_range(0, 1) == 0) new_data(1'($urandom));
            mem_if.addr_ok = (ph == 1) && ($urandom_range(0, 1) == 1);
            mem_if.data_ok = (ph == 2) && ($urandom_range(0, 1) == 1);
            mem_if.rdata   = $urandom;
            step();
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single sram-like memory port between the instruction-fetch requester (inst) and the execute-stage load/store requester (data). It grants one requester at a time, registers the granted request, and drives it downstream with one transaction outstanding. It routes the response back to the owner. Data has fixed priority, with a starvation guard for inst. The block sits between the pipeline stages and the memory bridge.

## Interface
- STARVE_MAX, 4: number of consecutive data grants made while inst is pending; after this count inst wins the next grant.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- inst_req, data_req  in  1 each  request valid; held until the matching addr_ok.
- inst_wr, data_wr  in  1 each  1 = write.
- inst_size, data_size  in  2 each  00 byte, 01 half, 10 word.
- inst_wstrb, data_wstrb  in  4 each  byte enables.
- inst_addr, data_addr  in  32 each  address.
- inst_wdata, data_wdata  in  32 each  write data.
- inst_addr_ok, data_addr_ok  out  1 each  request accepted.
- inst_data_ok, data_data_ok  out  1 each  response valid.
- inst_rdata, data_rdata  out  32 each  read data.
- m_req  out  1  downstream request.
- m_wr  out  1  downstream write flag.
- m_size  out  2  downstream size.
- m_wstrb  out  4  downstream byte enables.
- m_addr  out  32  downstream address.
- m_wdata  out  32  downstream write data.
- m_addr_ok  in  1  downstream request accepted.
- m_data_ok  in  1  downstream response valid.
- m_rdata  in  32  downstream read data.

## Operation
- State machine: IDLE, REQ, WAIT. Owner register: 0 = inst, 1 = data.
- IDLE, grant rules:
  - If data_req and inst_req are both high, data wins unless starve_cnt == STARVE_MAX; in that case inst wins.
  - If only one request is high, that requester wins.
- IDLE, on a grant:
  - Assert the winner's addr_ok combinationally in the same cycle.
  - Latch wr, size, wstrb, addr and wdata. Latch wstrb as 0000 when wr = 0.
  - Record the owner and go to REQ.
- IDLE, starvation counter:
  - A data grant while inst_req is high increments starve_cnt, saturating at STARVE_MAX.
  - An inst grant clears starve_cnt.
  - A data grant with inst_req low leaves starve_cnt unchanged.
- REQ:
  - m_req = 1 and the m_* outputs come from the latched payload.
  - On m_addr_ok go to WAIT.
  - No addr_ok is driven to either requester.
- WAIT:
  - m_req = 0.
  - On m_data_ok pulse the owner's data_ok for the same cycle and go to IDLE.
  - owner rdata = m_rdata combinationally.
  - The non-owner's data_ok stays 0.
- inst_rdata and data_rdata both carry m_rdata at all times; only data_ok qualifies them.
- m_data_ok in IDLE or REQ is ignored; it is a protocol error and is flagged by an assertion.
- Requests arriving in REQ or WAIT are not acknowledged; the requester holds them.
- m_size is passed through unchanged. The block does no alignment checks.

## Timing
- Reset, asserted asynchronously at any point including mid-transaction:
  - State returns to IDLE; starve_cnt and owner clear to 0.
  - m_req, all addr_ok, all data_ok and the latched payload reset to 0, so m_* outputs read 0.
  - The in-flight transaction is abandoned and no data_ok is generated for it.
- Cycle sequence with zero downstream wait:
  - Cycle 0: requester req high and the grant is given (addr_ok high).
  - Cycle 1: m_req high; m_addr_ok arrives.
  - Cycle 2: m_data_ok arrives and the owner's data_ok is high.
  - Cycle 3: back in IDLE; the next grant is possible.
- Peak throughput is one transaction per 3 cycles.
- m_* outputs are stable from REQ entry until m_addr_ok.
- addr_ok and data_ok are never both high for the same requester in one cycle.

## Structure
- The shared header mycpu.h holds the state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2), the owner IDs (OWN_INST = 1'b0, OWN_DATA = 1'b1) and the payload width MEM_REQ_WD = 71 (1 wr + 2 size + 4 wstrb + 32 addr + 32 wdata).
- One sub-module is natural: mem_req_reg, the payload latch with async clear and load enable.
- Everything else lives in mem_port_arbiter.

## Test plan
- Single data write: data_addr=0x1C000100, data_wdata=0xDEADBEEF, data_wstrb=1111, size=10. Expect data_addr_ok in cycle 0 and m_req with m_addr=0x1C000100 in cycle 1. With m_addr_ok in cycle 1 and m_data_ok in cycle 3, data_data_ok is high only in cycle 3.
- Both requesters high, inst_addr=0x1C000000 and data_addr=0x00000010. Data is granted first. Inst is granted in the first IDLE after data's m_data_ok, with m_addr=0x1C000000.
- Starvation, STARVE_MAX=4: inst_req and data_req held high continuously. Grants go data, data, data, data, inst. starve_cnt reads 0 after the inst grant.
- Read with wstrb=1111 and wr=0. Expect m_wstrb=0000. m_rdata=0x12345678 with m_data_ok appears on data_rdata with data_data_ok, while inst_data_ok stays 0.
- Downstream stall: m_addr_ok withheld for 5 cycles. m_req and m_addr stay constant throughout, and a new inst_req gets no addr_ok.
- Reset mid-WAIT: deassert resetn asynchronously. Expect m_req=0, all addr_ok and data_ok 0, and state IDLE immediately. A later m_data_ok produces no requester data_ok.
